// File: rtl/_shift_register_seq_pkg.sv
// Shared encodings and parameter helpers for the sequenced shift register.
package _shift_register_seq_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'b000,
        OP_LSR = 3'b001,
        OP_ASR = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100,
        OP_SIL = 3'b101,
        OP_SIR = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // One extra bit so an amount of exactly WIDTH (or more) is expressible.
    function automatic int aw_of(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/_shift_register_seq_shift1.sv
// Combinational single-step shifter: one 1-bit move of q plus the bit that leaves it.
module _shift1
    import _shift_register_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] q,
    input  op_e              op,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q_nxt,
    output logic             bit_out
);

    always_comb begin
        q_nxt   = q;
        bit_out = 1'b0;
        unique case (op)
            OP_LSL: begin q_nxt = {q[WIDTH-2:0], 1'b0};       bit_out = q[WIDTH-1]; end
            OP_LSR: begin q_nxt = {1'b0, q[WIDTH-1:1]};       bit_out = q[0];       end
            OP_ASR: begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; bit_out = q[0];       end
            OP_ROL: begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; bit_out = q[WIDTH-1]; end
            OP_ROR: begin q_nxt = {q[0], q[WIDTH-1:1]};       bit_out = q[0];       end
            OP_SIL: begin q_nxt = {q[WIDTH-2:0], serial_in};  bit_out = q[WIDTH-1]; end
            OP_SIR: begin q_nxt = {serial_in, q[WIDTH-1:1]};  bit_out = q[0];       end
            OP_NOP: begin q_nxt = q;                          bit_out = 1'b0;       end
            default: begin q_nxt = q;                         bit_out = 1'b0;       end
        endcase
    end

endmodule

// File: rtl/_shift_register_seq.sv
// Parallel-load register with a start/busy/done sequenced shift engine (one bit per clock).
module _shift_register_seq
    import _shift_register_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = aw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             serial_out
);

    state_e           state, state_nxt;
    op_e              op_r;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] q_step;
    logic             bit_step;

    _shift1 #(.WIDTH(WIDTH)) u_shift1 (
        .q         (q),
        .op        (op_r),
        .serial_in (serial_in),
        .q_nxt     (q_step),
        .bit_out   (bit_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (!load && start) state_nxt = (amount == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (cnt == AW'(1))  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load wins over start in IDLE; steps only run in SHIFT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q          <= '0;
            serial_out <= 1'b0;
            cnt        <= '0;
            op_r       <= OP_LSL;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        op_r <= op_e'(op);
                        cnt  <= amount;
                    end
                end
                S_SHIFT: begin
                    q   <= q_step;
                    cnt <= cnt - AW'(1);
                    if (op_r != OP_NOP) serial_out <= bit_step;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb__shift_register_seq.sv
// Directed self-checking bench for _shift_register_seq at WIDTH=8.
module tb__shift_register_seq;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [W-1:0]  d;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amount;
    logic          serial_in;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic          serial_out;

    int tests = 0;
    int fails = 0;
    int bcyc;

    localparam logic [2:0] LSL = 3'b000, ASR = 3'b010, ROL = 3'b011, ROR = 3'b100,
                           SIL = 3'b101, SIR = 3'b110, NOP = 3'b111, LSR = 3'b001;

    _shift_register_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .d(d), .start(start), .op(op),
        .amount(amount), .serial_in(serial_in), .q(q), .busy(busy), .done(done),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; d = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] o, input logic [AW-1:0] a);
        start = 1'b1; op = o; amount = a;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles until done shows up; a timeout shows up as done != 1.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) n++;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; d = '0; start = 1'b0; op = '0; amount = '0; serial_in = 1'b0;
        #12;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_so", serial_out, 1'b0);
        reset_n = 1'b1;
        tick();

        // LSL 3 on A5, stepwise
        do_load(8'hA5);
        chk("load_a5", q, 8'hA5);
        do_start(LSL, 4'd3);
        chk("lsl_busy1", busy, 1'b1);
        chk("lsl_q0", q, 8'hA5);
        tick(); chk("lsl_q1", q, 8'h4A); chk("lsl_so1", serial_out, 1'b1);
        tick(); chk("lsl_q2", q, 8'h94); chk("lsl_so2", serial_out, 1'b0);
        chk("lsl_busy3", busy, 1'b1);
        tick(); chk("lsl_q3", q, 8'h28);
        chk("lsl_done", done, 1'b1); chk("lsl_busy4", busy, 1'b0);
        chk("lsl_so", serial_out, 1'b1);
        tick(); chk("lsl_idle", done, 1'b0);

        // NOP keeps q and serial_out
        do_load(8'h5A);
        do_start(NOP, 4'd2);
        wait_done(bcyc);
        chk("nop_done", done, 1'b1); chk("nop_cyc", bcyc, 2);
        chk("nop_q", q, 8'h5A); chk("nop_so", serial_out, 1'b1);
        tick();

        // ASR 2 on 90
        do_load(8'h90);
        do_start(ASR, 4'd2);
        wait_done(bcyc);
        chk("asr_q", q, 8'hE4); chk("asr_so", serial_out, 1'b0); chk("asr_cyc", bcyc, 2);
        tick();

        // ROR 9 on 81 wraps to ROR 1
        do_load(8'h81);
        do_start(ROR, 4'd9);
        wait_done(bcyc);
        chk("ror_done", done, 1'b1); chk("ror_cyc", bcyc, 9);
        chk("ror_q", q, 8'hC0); chk("ror_so", serial_out, 1'b1);
        tick();

        // SIL 8 with serial_in held high
        do_load(8'h00);
        serial_in = 1'b1;
        do_start(SIL, 4'd8);
        wait_done(bcyc);
        chk("sil1_cyc", bcyc, 8); chk("sil1_q", q, 8'hFF); chk("sil1_so", serial_out, 1'b0);
        tick();

        // SIL 8 with serial_in toggling 1,0,1,0...
        do_load(8'h00);
        do_start(SIL, 4'd8);
        for (int i = 0; i < 8; i++) begin
            serial_in = (i % 2 == 0);
            tick();
        end
        chk("sil2_done", done, 1'b1); chk("sil2_q", q, 8'hAA);
        tick();

        // SIR fills from the top
        do_load(8'h00);
        serial_in = 1'b1;
        do_start(SIR, 4'd2);
        wait_done(bcyc);
        chk("sir_q", q, 8'hC0); chk("sir_so", serial_out, 1'b0);
        serial_in = 1'b0;
        tick();

        // amount 0: straight to DONE, no busy
        do_load(8'h3C);
        do_start(LSR, 4'd0);
        chk("zero_busy", busy, 1'b0); chk("zero_done", done, 1'b1); chk("zero_q", q, 8'h3C);
        tick(); chk("zero_idle", done, 1'b0);

        // load and start together: load wins, start dropped
        load = 1'b1; d = 8'h69; start = 1'b1; op = LSL; amount = 4'd1;
        tick();
        load = 1'b0; start = 1'b0;
        chk("ls_q", q, 8'h69); chk("ls_busy", busy, 1'b0); chk("ls_done", done, 1'b0);
        tick(); chk("ls_q2", q, 8'h69); chk("ls_busy2", busy, 1'b0);

        // load/start during busy are ignored
        do_load(8'h01);
        do_start(LSL, 4'd2);
        load = 1'b1; d = 8'hFF; start = 1'b1; op = LSR; amount = 4'd5;
        tick();
        load = 1'b0; start = 1'b0;
        wait_done(bcyc);
        chk("ign_q", q, 8'h04); chk("ign_done", done, 1'b1);
        tick();
        chk("ign_idle_q", q, 8'h04); chk("ign_idle_busy", busy, 1'b0);

        // asynchronous reset mid-shift
        do_load(8'hF0);
        do_start(ROL, 4'd6);
        tick();
        chk("pre_rst_so", serial_out, 1'b1); chk("pre_rst_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_q", q, 8'h00); chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0); chk("arst_so", serial_out, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        do_load(8'h80);
        do_start(LSR, 4'd1);
        chk("post_busy", busy, 1'b1);
        tick(); chk("post_done", done, 1'b1); chk("post_q", q, 8'h40);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/_shift_register_seq.md
Name: _shift_register_seq

Overview:
Parametrised WIDTH-bit register with parallel load and a sequenced multi-bit shift/rotate engine.
- A shift-by-N request executes one bit per clock under a start/busy/done handshake.
- Next-generation general-purpose register for datapaths and serial converters, replacing fixed-width plain registers where shift capability is needed.

Parameters:
- WIDTH, 32, data width in bits (>= 2).
- AW, $clog2(WIDTH)+1, width of the shift-amount input; allows shifts of 0..2^AW-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  parallel load request, sampled in IDLE only.
- d  input  WIDTH  parallel load data.
- start  input  1  shift request, sampled in IDLE only.
- op  input  3  shift operation, latched at start.
- amount  input  AW  number of 1-bit steps, latched at start.
- serial_in  input  1  fill bit for the SIL/SIR ops.
- q  output  WIDTH  register contents.
- busy  output  1  high while shift steps are executing.
- done  output  1  one-cycle completion pulse.
- serial_out  output  1  last bit shifted or rotated out, registered.

Behaviour:
- Reset (asynchronous, any time, including mid-shift): q=0, busy=0, done=0, serial_out=0, state=IDLE, internal counter=0, latched op=LSL.
- op encoding:
  - 000 LSL: fill 0.
  - 001 LSR: fill 0.
  - 010 ASR: fill q[WIDTH-1].
  - 011 ROL.
  - 100 ROR.
  - 101 SIL: left, fill serial_in.
  - 110 SIR: right, fill serial_in.
  - 111 NOP: step leaves q unchanged and serial_out unchanged.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: q<=d at the edge and state stays IDLE. load has priority; a simultaneous start is dropped, not queued.
  - start=1, load=0: latch op; cnt<=amount. If amount==0, go to DONE. Otherwise go to SHIFT. q is unchanged at this edge.
- SHIFT:
  - Each edge performs one 1-bit step on q using the latched op, captures the exiting bit into serial_out, and decrements cnt.
  - When cnt==1 at the edge, go to DONE.
- DONE: one cycle, then IDLE.
- Outputs:
  - busy is 1 exactly when state==SHIFT.
  - done is 1 exactly when state==DONE.
  - Both are state-decoded from registers, with no combinational path from inputs.
- Latency: for amount=k>0, busy is high for k cycles starting the cycle after the start edge. done pulses in cycle k+1. q is final when done is high.
- Exiting bit: q[WIDTH-1] for left ops, q[0] for right ops.
- Ignored inputs: load and start are ignored in SHIFT and DONE. serial_in is sampled every step of SIL/SIR, so it may change per cycle.
- amount > WIDTH is legal: steps simply continue (shifts saturate to fill pattern, rotates wrap modulo WIDTH).

Decomposition:
- Shared package: op encodings (OP_LSL..OP_NOP), state encodings (S_IDLE, S_SHIFT, S_DONE), and the AW derivation function.
- Sub-module _shift1: combinational single-step shifter.
  - Inputs: q, op, serial_in.
  - Outputs: next q and the exiting bit.
- The top holds the FSM, counter, q and serial_out registers.

Test Plan:
(All scenarios use WIDTH=8.)
- Reset: assert reset_n=0 mid-shift (busy=1) -> q=0x00, busy=0, done=0 and serial_out=0 immediately, without waiting for a clock edge. Release -> IDLE, and the next start is accepted.
- Load 0xA5, then start LSL amount=3 -> busy high 3 cycles, q=0x4A, 0x94, 0x28 per step. done pulses on cycle 4. serial_out=1 at done.
- Load 0x90, ASR amount=2 -> q=0xE4, serial_out=0. Then ROR amount=9 on a reloaded 0x81 -> q=0xC0 after 9 busy cycles.
- Load 0x00, SIL amount=8 with serial_in=1 held -> q=0xFF, done after 9 cycles. Repeat with serial_in toggling 1,0,1,0... -> q=0xAA.
- Start with amount=0 -> busy never asserts, done high the next cycle, q unchanged.
- Simultaneous load=1/start=1 in IDLE -> q=d and no shift.
- start or load pulsed during busy -> ignored, and the in-flight result is unchanged.
